// File: rtl/div_ctrl.sv
// div_ctrl: radix-2 restoring divider plus stall sequencer for MIPS DIV/DIVU in E.
// Optional macro DIV_EARLY_OUT_EN: finish in the accept cycle when |divisor| > |dividend|.
module div_ctrl #(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         signed_div,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  input  logic         annul,
  output logic         stall_div,
  output logic         result_valid,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   counter;
  logic [W-1:0]       rem_q;
  logic [W-1:0]       dvd_q;
  logic [W-1:0]       dvs_q;
  logic [W-1:0]       raw_a_q;
  logic               q_neg;
  logic               r_neg;
  logic               div_zero;

  logic               accept;
  logic               early;
  logic [W-1:0]       mag_a;
  logic [W-1:0]       mag_b;
  logic [W:0]         trial;
  logic [W-1:0]       rem_next;
  logic [W-1:0]       quo_next;

  assign accept = (state == IDLE) && start && !annul;
  assign mag_a  = (signed_div && opa[W-1]) ? (~opa + 1'b1) : opa;
  assign mag_b  = (signed_div && opb[W-1]) ? (~opb + 1'b1) : opb;

`ifdef DIV_EARLY_OUT_EN
  assign early = (mag_b > mag_a) && (opb != '0);
`else
  assign early = 1'b0;
`endif

  // One restoring step: the dividend register doubles as the quotient shift register.
  assign trial    = {rem_q, dvd_q[W-1]} - {1'b0, dvs_q};
  assign rem_next = trial[W] ? {rem_q[W-2:0], dvd_q[W-1]} : trial[W-1:0];
  assign quo_next = {dvd_q[W-2:0], ~trial[W]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = early ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (counter == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (annul) begin
      state_next = IDLE;
    end
  end

  // Never hold the pipeline during reset or a flush.
  always_comb begin
    stall_div = 1'b0;
    if (resetn && !annul) begin
      case (state)
        IDLE:    stall_div = start;
        BUSY:    stall_div = 1'b1;
        default: stall_div = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      counter      <= '0;
      rem_q        <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      raw_a_q      <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      div_zero     <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rem_q    <= '0;
            dvd_q    <= mag_a;
            dvs_q    <= mag_b;
            raw_a_q  <= opa;
            q_neg    <= signed_div && (opa[W-1] ^ opb[W-1]);
            r_neg    <= signed_div && opa[W-1];
            div_zero <= (opb == '0);
            counter  <= CNT_W'(W - 1);
            if (early) begin
              hi           <= opa;
              lo           <= '0;
              result_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (!annul) begin
            rem_q   <= rem_next;
            dvd_q   <= quo_next;
            counter <= counter - 1'b1;
            // Last step: apply sign fix-up, or the divide-by-zero convention.
            if (counter == '0) begin
              result_valid <= 1'b1;
              if (div_zero) begin
                lo <= '1;
                hi <= raw_a_q;
              end else begin
                lo <= q_neg ? (~quo_next + 1'b1) : quo_next;
                hi <= r_neg ? (~rem_next + 1'b1) : rem_next;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed stimulus for div_ctrl, checked every cycle against an arithmetic model.
// Honors DIV_EARLY_OUT_EN the same way the design does.
module tb_div_ctrl;

  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_STALLS = 1;
  localparam bit EARLY_ON     = 1'b1;
`else
  localparam int EARLY_STALLS = 33;
  localparam bit EARLY_ON     = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic         signed_div;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         annul;
  logic         stall_div;
  logic         result_valid;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  div_ctrl #(.W(W), .CNT_W(6)) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .signed_div(signed_div),
    .opa(opa),
    .opb(opb),
    .annul(annul),
    .stall_div(stall_div),
    .result_valid(result_valid),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Reference result from plain 64-bit arithmetic (truncating division, remainder takes dividend sign).
  task automatic modelDiv(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] mhi, output logic [W-1:0] mlo, output bit short_cut);
    longint sa, sb, ma, mb, q, r;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    short_cut = EARLY_ON && (b != 0) && (mb > ma);
    if (b == 0) begin
      mlo = '1;
      mhi = a;
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      mlo = q[W-1:0];
      mhi = r[W-1:0];
    end
  endtask

  int           busy_left = 0;
  bit           m_done    = 1'b0;
  logic         m_rv      = 1'b0;
  logic [W-1:0] m_hi      = '0;
  logic [W-1:0] m_lo      = '0;
  logic [W-1:0] p_hi      = '0;
  logic [W-1:0] p_lo      = '0;

  // Model: an accepted divide occupies W busy cycles, then one result cycle.
  always @(posedge clk) begin
    logic [W-1:0] th, tl;
    bit sc;
    cyc++;
    m_rv = 1'b0;
    if (!resetn) begin
      busy_left = 0;
      m_done    = 1'b0;
      m_hi      = '0;
      m_lo      = '0;
    end else if (annul) begin
      busy_left = 0;
      m_done    = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        m_done = 1'b1;
        m_rv   = 1'b1;
        m_hi   = p_hi;
        m_lo   = p_lo;
      end
    end else if (start) begin
      modelDiv(signed_div, opa, opb, th, tl, sc);
      p_hi = th;
      p_lo = tl;
      if (sc) begin
        m_done = 1'b1;
        m_rv   = 1'b1;
        m_hi   = th;
        m_lo   = tl;
      end else begin
        busy_left = W;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("stall_div", stall_div,
                  W'(resetn && !annul && (busy_left > 0 || (!m_done && start))));
      checkOutput("result_valid", result_valid, W'(m_rv));
      checkOutput("hi", hi, m_hi);
      checkOutput("lo", lo, m_lo);
    end
  end

  task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                               output int stalls, output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                               output logic rv);
    int n;
    @(posedge clk); #1;
    start = 1'b1; signed_div = sgn; opa = a; opb = b;
    stalls = 0;
    n = 0;
    @(negedge clk);
    while (stall_div && n < 200) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL stall_timeout actual=%0d required<200", n);
    end
    rhi = hi;
    rlo = lo;
    rv  = result_valid;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitResult(output int at_cycle);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!result_valid && n < 100);
    if (!result_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL result_timeout actual=%0d required<100", n);
    end
    at_cycle = cyc;
  endtask

  typedef struct {
    string        name;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           stalls;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int st, t1, t2;
    logic [W-1:0] rh, rl;
    logic rv;

    vecs.push_back('{"divu_7_2",    1'b0, 32'd7,        32'd2,        33, 32'h1,        32'h3});
    vecs.push_back('{"div_m7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"div_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0,        32'h80000000});
    vecs.push_back('{"div_100_m7",  1'b1, 32'd100,      32'hFFFFFFF9, 33, 32'h2,        32'hFFFFFFF2});
    vecs.push_back('{"div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 33, 32'hFFFFFFFE, 32'hE});
    vecs.push_back('{"divu_5_0",    1'b0, 32'd5,        32'd0,        33, 32'h5,        32'hFFFFFFFF});
    vecs.push_back('{"div_m5_0",    1'b1, 32'hFFFFFFFB, 32'd0,        33, 32'hFFFFFFFB, 32'hFFFFFFFF});

    resetn = 1'b0; start = 1'b0; signed_div = 1'b0; opa = '0; opb = '0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_hi", hi, 32'h0);
    checkOutput("reset_lo", lo, 32'h0);
    checkOutput("reset_rv", result_valid, 32'h0);
    checkOutput("reset_stall", stall_div, 32'h0);
    @(posedge clk); #1 resetn = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, st, rh, rl, rv);
      checkOutput({vecs[i].name, "_stalls"}, W'(st), W'(vecs[i].stalls));
      checkOutput({vecs[i].name, "_hi"}, rh, vecs[i].ehi);
      checkOutput({vecs[i].name, "_lo"}, rl, vecs[i].elo);
      checkOutput({vecs[i].name, "_rv"}, W'(rv), 32'h1);
    end

    // Flush in BUSY cycle 10: no result, previous HI/LO kept.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b1; opa = 32'd100; opb = 32'd7;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    checkOutput("annul_stall", stall_div, 32'h0);
    @(posedge clk); #1 annul = 1'b0; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("annul_rv", result_valid, 32'h0);
    end
    checkOutput("annul_hi_kept", hi, 32'hFFFFFFFB);
    checkOutput("annul_lo_kept", lo, 32'hFFFFFFFF);
    applyStimulus(1'b0, 32'd100, 32'd7, st, rh, rl, rv);
    checkOutput("divu_100_7_hi", rh, 32'd2);
    checkOutput("divu_100_7_lo", rl, 32'd14);

    // Back-to-back: second operands enter E at the DONE->IDLE edge.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opa = 32'd9; opb = 32'd3;
    waitResult(t1);
    checkOutput("b2b_first_lo", lo, 32'd3);
    checkOutput("b2b_first_hi", hi, 32'd0);
    @(posedge clk); #1 opa = 32'd10; opb = 32'd4;
    waitResult(t2);
    checkOutput("b2b_second_lo", lo, 32'd2);
    checkOutput("b2b_second_hi", hi, 32'd2);
    checkOutput("b2b_spacing", W'(t2 - t1), 32'd34);
    @(posedge clk); #1 start = 1'b0;

    // Reset in the middle of a divide.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3;
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy_stall", stall_div, 32'h0);
    @(posedge clk); #1 resetn = 1'b1; start = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy_hi", hi, 32'h0);
    checkOutput("rst_busy_lo", lo, 32'h0);
    checkOutput("rst_busy_stall_after", stall_div, 32'h0);

    applyStimulus(1'b0, 32'd3, 32'd10, st, rh, rl, rv);
    checkOutput("early_stalls", W'(st), W'(EARLY_STALLS));
    checkOutput("early_hi", rh, 32'd3);
    checkOutput("early_lo", rl, 32'd0);
    checkOutput("early_rv", W'(rv), 32'h1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
